// File: rtl/cpu_pkg.sv
// Shared types, instruction field layout and helpers for the lab-datapath control unit.
package cpu_pkg;

    localparam int unsigned INST_W    = 16;
    localparam int unsigned REG_IDX_W = 3;
    localparam int unsigned OP_W      = 3;
    localparam int unsigned IMM8_W    = 8;
    localparam int unsigned FMT_W     = 2;

    localparam int unsigned RX_LSB  = 13;
    localparam int unsigned RY_LSB  = 10;
    localparam int unsigned IMM_LSB = 5;
    localparam int unsigned OP_LSB  = 2;
    localparam int unsigned FMT_LSB = 0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        EXEC   = 3'd2,
        WRITE  = 3'd3,
        MOVE   = 3'd4,
        ERR    = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        FMT_R   = 2'b00,
        FMT_I   = 2'b01,
        FMT_MV  = 2'b10,
        FMT_BAD = 2'b11
    } fmt_e;

    typedef enum logic {
        SRC_IMM = 1'b0,
        SRC_G   = 1'b1
    } bus_src_e;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rx;
        logic [REG_IDX_W-1:0] ry;
        logic [OP_W-1:0]      op;
        fmt_e                 fmt;
        logic                 illegal;
    } dec_t;

    // Bus-select codes above the register range: immediate first, then G.
    function automatic int unsigned mux_code(input int unsigned nregs, input bus_src_e src);
        return (src == SRC_G) ? nregs + 1 : nregs;
    endfunction

    // Register indices must exist; ry only matters for the formats that read it.
    function automatic logic inst_illegal(input logic [REG_IDX_W-1:0] rx,
                                          input logic [REG_IDX_W-1:0] ry,
                                          input fmt_e                 fmt,
                                          input int unsigned          nregs);
        logic rx_bad;
        logic ry_bad;
        rx_bad = 32'(rx) >= nregs;
        ry_bad = (fmt != FMT_I) && (32'(ry) >= nregs);
        return (fmt == FMT_BAD) || rx_bad || ry_bad;
    endfunction

endpackage

// File: rtl/cpu_decode.sv
// Combinational field decode of a latched instruction, including immediate extension.
module cpu_decode
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned NREGS      = 8,
    parameter int unsigned IMM_SIGNED = 0
) (
    input  logic [INST_W-1:0] inst,
    output dec_t              dec,
    output logic [DATA_W-1:0] imm_ext
);

    logic [REG_IDX_W-1:0] rx;
    logic [REG_IDX_W-1:0] ry;
    logic [OP_W-1:0]      op;
    logic [IMM8_W-1:0]    imm8;
    fmt_e                 fmt;
    logic                 ext_bit;

    assign rx   = inst[RX_LSB +: REG_IDX_W];
    assign ry   = inst[RY_LSB +: REG_IDX_W];
    assign op   = inst[OP_LSB +: OP_W];
    assign imm8 = inst[IMM_LSB +: IMM8_W];
    assign fmt  = fmt_e'(inst[FMT_LSB +: FMT_W]);

    assign dec = '{
        rx:      rx,
        ry:      ry,
        op:      op,
        fmt:     fmt,
        illegal: inst_illegal(rx, ry, fmt, NREGS)
    };

    // Replicate the extension bit above imm8, then keep the low DATA_W bits.
    assign ext_bit = (IMM_SIGNED != 0) && imm8[IMM8_W-1];
    assign imm_ext = DATA_W'({{DATA_W{ext_bit}}, imm8});

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle control unit: latches one instruction per run handshake and sequences
// bus-select, register-enable and ALU-op controls as Moore decodes of state and inst_q.
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter  int unsigned DATA_W     = 16,
    parameter  int unsigned NREGS      = 8,
    parameter  int unsigned IMM_SIGNED = 0,
    localparam int unsigned MUX_W      = $clog2(NREGS + 2)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    input  logic [INST_W-1:0] d_inst,
    output logic              busy,
    output logic              en_inst,
    output logic [MUX_W-1:0]  mux_sel,
    output logic [DATA_W-1:0] im_d,
    output logic [OP_W-1:0]   sel,
    output logic              en_s,
    output logic              en_c,
    output logic [NREGS-1:0]  en,
    output logic              done,
    output logic              err
);

    state_e            state_q;
    state_e            state_d;
    logic [INST_W-1:0] inst_q;
    dec_t              dec;
    logic [NREGS-1:0]  rx_onehot;
    logic              accept;
    fmt_e              new_fmt;
    logic              new_illegal;

    cpu_decode #(
        .DATA_W     (DATA_W),
        .NREGS      (NREGS),
        .IMM_SIGNED (IMM_SIGNED)
    ) u_decode (
        .inst    (inst_q),
        .dec     (dec),
        .imm_ext (im_d)
    );

    // Dispatch needs only the format and legality of the incoming word.
    assign new_fmt     = fmt_e'(d_inst[FMT_LSB +: FMT_W]);
    assign new_illegal = inst_illegal(d_inst[RX_LSB +: REG_IDX_W],
                                      d_inst[RY_LSB +: REG_IDX_W], new_fmt, NREGS);

    assign accept    = (state_q == IDLE) && run;
    assign rx_onehot = dec.illegal ? '0 : NREGS'(1) << dec.rx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                inst_q <= d_inst;
            end
        end
    end

    always_comb begin
        state_d = IDLE;
        busy    = 1'b0;
        en_inst = 1'b0;
        mux_sel = '0;
        sel     = '0;
        en_s    = 1'b0;
        en_c    = 1'b0;
        en      = '0;
        done    = 1'b0;
        err     = 1'b0;
        case (state_q)
            IDLE: begin
                // No acceptance edge can occur while reset is held.
                en_inst = run && reset_n;
                if (run) begin
                    if (new_illegal) begin
                        state_d = ERR;
                    end else if (new_fmt == FMT_MV) begin
                        state_d = MOVE;
                    end else begin
                        state_d = LOAD_A;
                    end
                end
            end
            LOAD_A: begin
                busy    = 1'b1;
                mux_sel = MUX_W'(dec.rx);
                en_s    = 1'b1;
                state_d = EXEC;
            end
            EXEC: begin
                busy    = 1'b1;
                mux_sel = (dec.fmt == FMT_I) ? MUX_W'(mux_code(NREGS, SRC_IMM))
                                             : MUX_W'(dec.ry);
                sel     = dec.op;
                en_c    = 1'b1;
                state_d = WRITE;
            end
            WRITE: begin
                busy    = 1'b1;
                mux_sel = MUX_W'(mux_code(NREGS, SRC_G));
                en      = rx_onehot;
                done    = 1'b1;
            end
            MOVE: begin
                busy    = 1'b1;
                mux_sel = MUX_W'(dec.ry);
                en      = rx_onehot;
                done    = 1'b1;
            end
            ERR: begin
                busy = 1'b1;
                err  = 1'b1;
                done = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Bench for cpu_ctrl: directed vector table, corner sequences and random run traffic
// checked against an instruction-level reference model on two configurations.
module tb_cpu_ctrl;

    typedef struct packed {
        logic        busy;
        logic        en_inst;
        logic [3:0]  mux;
        logic [15:0] im_d;
        logic [2:0]  sel;
        logic        en_s;
        logic        en_c;
        logic [7:0]  en;
        logic        done;
        logic        err;
    } obs_t;

    typedef struct {
        logic        rn;
        logic        run;
        logic [15:0] d;
        obs_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run;
    logic [15:0] d_inst;

    logic        busy_a, en_inst_a, en_s_a, en_c_a, done_a, err_a;
    logic [3:0]  mux_a;
    logic [15:0] im_a;
    logic [2:0]  sel_a;
    logic [7:0]  en_a;

    logic        busy_b, en_inst_b, en_s_b, en_c_b, done_b, err_b;
    logic [2:0]  mux_b;
    logic [15:0] im_b;
    logic [2:0]  sel_b;
    logic [3:0]  en_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cpu_ctrl #(.DATA_W(16), .NREGS(8), .IMM_SIGNED(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .run(run), .d_inst(d_inst),
        .busy(busy_a), .en_inst(en_inst_a), .mux_sel(mux_a), .im_d(im_a),
        .sel(sel_a), .en_s(en_s_a), .en_c(en_c_a), .en(en_a),
        .done(done_a), .err(err_a)
    );

    cpu_ctrl #(.DATA_W(16), .NREGS(4), .IMM_SIGNED(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .run(run), .d_inst(d_inst),
        .busy(busy_b), .en_inst(en_inst_b), .mux_sel(mux_b), .im_d(im_b),
        .sel(sel_b), .en_s(en_s_b), .en_c(en_c_b), .en(en_b),
        .done(done_b), .err(err_b)
    );

    // Reference model: per config, the latched word and the cycle index within it.
    int          m_nregs [2] = '{8, 4};
    bit          m_sgn   [2] = '{1'b0, 1'b1};
    int          m_step  [2] = '{0, 0};
    logic [15:0] m_inst  [2] = '{16'h0, 16'h0};

    function automatic bit legal(int c, logic [15:0] q);
        int rx = int'(q[15:13]);
        int ry = int'(q[12:10]);
        if (q[1:0] == 2'b11 || rx >= m_nregs[c]) return 1'b0;
        return (q[1:0] == 2'b01) || (ry < m_nregs[c]);
    endfunction

    function automatic int n_cycles(int c, logic [15:0] q);
        return (legal(c, q) && q[1:0] != 2'b10) ? 3 : 1;
    endfunction

    function automatic obs_t model_exp(int c, logic r, logic rn);
        obs_t        o    = '0;
        logic [15:0] q    = m_inst[c];
        int          rx   = int'(q[15:13]);
        int          ry   = int'(q[12:10]);
        int          nr   = m_nregs[c];
        logic [7:0]  imm8 = q[12:5];
        o.im_d = {(m_sgn[c] && imm8[7]) ? 8'hFF : 8'h00, imm8};
        if (m_step[c] == 0) begin
            o.en_inst = r && rn;
            return o;
        end
        o.busy = 1'b1;
        if (!legal(c, q)) begin
            o.err  = 1'b1;
            o.done = 1'b1;
        end else if (q[1:0] == 2'b10) begin
            o.mux  = 4'(ry);
            o.en   = 8'(1) << rx;
            o.done = 1'b1;
        end else begin
            case (m_step[c])
                1: begin
                    o.mux  = 4'(rx);
                    o.en_s = 1'b1;
                end
                2: begin
                    o.mux  = (q[1:0] == 2'b00) ? 4'(ry) : 4'(nr);
                    o.sel  = q[4:2];
                    o.en_c = 1'b1;
                end
                default: begin
                    o.mux  = 4'(nr + 1);
                    o.en   = 8'(1) << rx;
                    o.done = 1'b1;
                end
            endcase
        end
        return o;
    endfunction

    function automatic obs_t mk(logic b, logic ei, logic [3:0] m, logic [15:0] im,
                                logic [2:0] s, logic es, logic ec, logic [7:0] e,
                                logic dn, logic er);
        return {b, ei, m, im, s, es, ec, e, dn, er};
    endfunction

    function automatic obs_t obs_a();
        return {busy_a, en_inst_a, mux_a, im_a, sel_a, en_s_a, en_c_a, en_a, done_a, err_a};
    endfunction

    function automatic obs_t obs_b();
        return {busy_b, en_inst_b, 4'(mux_b), im_b, sel_b, en_s_b, en_c_b, 8'(en_b),
                done_b, err_b};
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s t=%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge and compare both DUTs.
    task automatic apply(input logic rn, input logic r, input logic [15:0] d);
        reset_n = rn;
        run     = r;
        d_inst  = d;
        #1;
        if (!rn) begin
            for (int c = 0; c < 2; c++) begin
                m_step[c] = 0;
                m_inst[c] = '0;
            end
        end
        check("model_a", obs_a(), model_exp(0, r, rn));
        check("model_b", obs_b(), model_exp(1, r, rn));
    endtask

    // Account for the coming rising edge in the model, then move to the next cycle.
    task automatic advance();
        for (int c = 0; c < 2; c++) begin
            if (reset_n) begin
                if (m_step[c] == 0) begin
                    if (run) begin
                        m_inst[c] = d_inst;
                        m_step[c] = 1;
                    end
                end else if (m_step[c] >= n_cycles(c, m_inst[c])) begin
                    m_step[c] = 0;
                end else begin
                    m_step[c]++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            apply(1'b1, 1'b0, 16'h0000);
            advance();
        end
    endtask

    vec_t vecs [14];

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 16'h4808, mk(0, 0, 0, 16'h0000, 0, 0, 0, 8'h00, 0, 0)};
        vecs[1]  = '{1'b1, 1'b1, 16'h4808, mk(0, 1, 0, 16'h0000, 0, 0, 0, 8'h00, 0, 0)};
        vecs[2]  = '{1'b1, 1'b0, 16'h0000, mk(1, 0, 2, 16'h0040, 0, 1, 0, 8'h00, 0, 0)};
        vecs[3]  = '{1'b1, 1'b0, 16'h0000, mk(1, 0, 2, 16'h0040, 2, 0, 1, 8'h00, 0, 0)};
        vecs[4]  = '{1'b1, 1'b0, 16'h0000, mk(1, 0, 9, 16'h0040, 0, 0, 0, 8'h04, 1, 0)};
        vecs[5]  = '{1'b1, 1'b1, 16'hBFE5, mk(0, 1, 0, 16'h0040, 0, 0, 0, 8'h00, 0, 0)};
        vecs[6]  = '{1'b1, 1'b0, 16'h0000, mk(1, 0, 5, 16'h00FF, 0, 1, 0, 8'h00, 0, 0)};
        vecs[7]  = '{1'b1, 1'b0, 16'h0000, mk(1, 0, 8, 16'h00FF, 1, 0, 1, 8'h00, 0, 0)};
        vecs[8]  = '{1'b1, 1'b0, 16'h0000, mk(1, 0, 9, 16'h00FF, 0, 0, 0, 8'h20, 1, 0)};
        vecs[9]  = '{1'b1, 1'b1, 16'h3802, mk(0, 1, 0, 16'h00FF, 0, 0, 0, 8'h00, 0, 0)};
        vecs[10] = '{1'b1, 1'b1, 16'h0003, mk(1, 0, 6, 16'h00C0, 0, 0, 0, 8'h02, 1, 0)};
        vecs[11] = '{1'b1, 1'b1, 16'h0003, mk(0, 1, 0, 16'h00C0, 0, 0, 0, 8'h00, 0, 0)};
        vecs[12] = '{1'b1, 1'b0, 16'h0000, mk(1, 0, 0, 16'h0000, 0, 0, 0, 8'h00, 1, 1)};
        vecs[13] = '{1'b1, 1'b0, 16'h0000, mk(0, 0, 0, 16'h0000, 0, 0, 0, 8'h00, 0, 0)};

        reset_n = 1'b1;
        run     = 1'b0;
        d_inst  = 16'h0000;
        #2;

        for (int i = 0; i < 14; i++) begin
            apply(vecs[i].rn, vecs[i].run, vecs[i].d);
            check($sformatf("vec%0d", i), obs_a(), vecs[i].exp);
            advance();
        end

        // Signed immediate on the 4-register build; rx=5 also makes it illegal there.
        apply(1'b1, 1'b1, 16'hBFE5);
        advance();
        apply(1'b1, 1'b0, 16'h0000);
        check("b_imm_signed_err", obs_b(), mk(1, 0, 0, 16'hFFFF, 0, 0, 0, 8'h00, 1, 1));
        advance();
        idle(3);

        // R-type with ry=5 takes the error path on NREGS=4 without any enable.
        apply(1'b1, 1'b1, 16'h3400);
        advance();
        apply(1'b1, 1'b0, 16'h0000);
        check("b_ry_oob", obs_b(), mk(1, 0, 0, 16'hFFA0, 0, 0, 0, 8'h00, 1, 1));
        advance();
        idle(3);

        // d_inst changes during EXEC must not retarget the write.
        apply(1'b1, 1'b1, 16'h4808);
        advance();
        apply(1'b1, 1'b0, 16'h4808);
        advance();
        apply(1'b1, 1'b0, 16'hE000);
        advance();
        apply(1'b1, 1'b0, 16'hE000);
        check("a_latched_rx", obs_a(), mk(1, 0, 9, 16'h0040, 0, 0, 0, 8'h04, 1, 0));
        advance();
        idle(1);

        // Reset pulled during EXEC: outputs clear at once, no done afterwards.
        apply(1'b1, 1'b1, 16'h4808);
        advance();
        apply(1'b1, 1'b0, 16'h0000);
        advance();
        apply(1'b0, 1'b0, 16'h0000);
        check("a_reset_exec", obs_a(), mk(0, 0, 0, 16'h0000, 0, 0, 0, 8'h00, 0, 0));
        advance();
        apply(1'b1, 1'b0, 16'h0000);
        check("a_idle_after_reset", obs_a(), mk(0, 0, 0, 16'h0000, 0, 0, 0, 8'h00, 0, 0));
        advance();
        idle(2);

        for (int i = 0; i < 2000; i++) begin
            apply(($urandom_range(0, 49) != 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                  16'($urandom));
            advance();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl.md
# cpu_ctrl

Parametrised multi-cycle control unit for the lab datapath: register file, A/G registers, ALU and bus multiplexer. Accepts one 16-bit instruction per run handshake and latches it internally, so the instruction source may change after acceptance. Sequences bus-select, register-enable and ALU-op controls through a decoded state machine. Supports register, immediate and move formats, flags illegal encodings, and scales to NREGS registers and DATA_W-bit data.

## Interface
- `DATA_W`, 16: datapath width; `im_d` width.
- `NREGS`, 8: register-file size, 2..8.
- `IMM_SIGNED`, 0: 1 sign-extends the 8-bit immediate to DATA_W; 0 zero-extends it.
- `MUX_W`, $clog2(NREGS+2): bus-select width, derived and not overridable.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  start request; sampled only in IDLE.
- `d_inst`  in  16  instruction; sampled only on acceptance.
- `busy`  out  1  high in every state except IDLE.
- `en_inst`  out  1  acceptance strobe: IDLE && run.
- `mux_sel`  out  MUX_W  bus source: 0..NREGS-1 selects a register, NREGS selects the immediate, NREGS+1 selects G.
- `im_d`  out  DATA_W  extended immediate of the latched instruction.
- `sel`  out  3  ALU op.
- `en_s`  out  1  load A from the bus.
- `en_c`  out  1  load G from the ALU.
- `en`  out  NREGS  one-hot register write enable.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle illegal-instruction pulse, coincident with `done`.

## Operation
Instruction fields:
- [15:13] rx, destination and first operand.
- [12:10] ry, second operand.
- [12:5] imm8.
- [4:2] op.
- [1:0] fmt: 00 R (rx = rx op ry), 01 I (rx = rx op imm), 10 MV (rx = ry), 11 illegal.

An instruction is also illegal if rx ≥ NREGS, or if fmt ∈ {00,10} and ry ≥ NREGS.

States:
- IDLE. If run=1: latch d_inst into inst_q; go to LOAD_A for R/I, MOVE for MV, ERR for illegal. Otherwise stay.
- LOAD_A: mux_sel=rx, en_s=1 → EXEC.
- EXEC: mux_sel=ry for R or NREGS for I; sel=op; en_c=1 → WRITE.
- WRITE: mux_sel=NREGS+1; en[rx]=1; done=1 → IDLE.
- MOVE: mux_sel=ry; en[rx]=1; done=1 → IDLE.
- ERR: err=1; done=1; en all zero → IDLE.

Output rules:
- Outputs not listed for a state are 0. `mux_sel` is 0 and `sel` is 0 where not listed.
- Decoding always uses inst_q. `d_inst` changes after acceptance have no effect.
- `im_d` is driven continuously from inst_q.
- Reset state: state=IDLE and inst_q=0, so every output is 0. `im_d`=0.
- Asserting reset_n mid-instruction aborts it. No `done` and no `en` pulse is produced.
- Invalid state encodings recover to IDLE on the next edge with all outputs 0.

## Timing
- Acceptance cycle t0 is IDLE with run=1.
- R/I: en_s at t1, en_c at t2, en[rx] and done at t3. Back in IDLE at t4.
- MV: en[rx] and done at t1. ERR: err and done at t1.
- run is ignored while busy=1. A run held high is accepted again at t4 (R/I) or t2 (MV/ERR), giving back-to-back issue with no idle gap beyond IDLE itself.
- All control outputs are Moore decodes of state and inst_q, except `en_inst`, which is combinational from run.
- At most one bit of `en` is set in any cycle. `en_s`, `en_c` and `en` are mutually exclusive.

## Structure
- Package `cpu_pkg` holds:
  - the state enum {IDLE, LOAD_A, EXEC, WRITE, MOVE, ERR};
  - the fmt enum {FMT_R, FMT_I, FMT_MV, FMT_BAD};
  - field position localparams;
  - a function for the mux_sel codes of IMM and G.
- Sub-module `cpu_decode` is purely combinational. It maps inst_q and NREGS to {rx, ry, op, fmt, imm_ext, illegal}. `cpu_ctrl` holds the state register, inst_q and the output decode.

## Test plan
- Reset: hold reset_n=0 with run=1 → busy=0, done=0, en=0, mux_sel=0, im_d=0. Release reset_n; `run` accepted on the next edge.
- R-type, d_inst=16'h4808 (rx=2, ry=2, op=2, fmt=00):
  - t1: mux_sel=2, en_s=1.
  - t2: mux_sel=2, sel=2, en_c=1.
  - t3: mux_sel=9, en=8'h04, done=1.
- I-type, d_inst=16'hBFE5 (rx=5, imm=0xFF, op=1):
  - IMM_SIGNED=0: im_d=16'h00FF; t2: mux_sel=8, sel=1; t3: en=8'h20.
  - IMM_SIGNED=1: im_d=16'hFFFF.
- MV rx=1, ry=6, then illegal fmt=11 held on run:
  - MV: t1 mux_sel=6, en=8'h02, done=1.
  - Illegal, accepted at t2: t3 err=1, done=1, en=0.
- NREGS=4, R-type with ry=5 → ERR path; no enable asserted. Change d_inst during EXEC → WRITE still targets the latched rx.
- Pull reset_n low during EXEC → all outputs 0 immediately. No done. IDLE after release.
